reg_rename_file: RTL and testbench

//  Architectural register file plus per-register rename-tag table; the commit-side partner of the ROB.

---
 rtl/reg_rename_file.sv | 125 ++++++++++++
 tb/tb_reg_rename_file.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// reg_rename_file
//   Architectural register file plus a rename-tag table for each register.
//   This is the commit-side partner of the ROB. Dispatch marks a destination
//   register as pending on a ROB tag. A ROB commit writes the value and clears
//   the tag only if the tag still matches. A ROB flush (clear) drops every
//   pending tag. A tag of 0 means the register value is final.
//
// Ports
//   clk_in, rst_in       clock, asynchronous active-high reset
//   rdy_in               global enable; when 0, all state holds
//   clear                ROB flush pulse: drop all tags, ignore dispatch
//   dispatch_rdy         dispatch of one instruction this cycle
//   disp_rd, disp_tag    destination register and allocated ROB tag
//   disp_rs1, disp_rs2   source register indices
//   rs1_val / rs1_rely   value / pending tag of disp_rs1 (commit-bypassed)
//   rs2_val / rs2_rely   value / pending tag of disp_rs2 (commit-bypassed)
//   write_rdy            ROB commit writes a register this cycle
//   to_rd, write_val     commit destination and value
//   head_tag             ROB tag of the committing entry
//   pending_cnt          number of registers with a nonzero tag (debug)
module reg_rename_file #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 5,
  parameter int XLEN     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dispatch_rdy,
  input  logic [4:0]       disp_rd,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [4:0]       disp_rs1,
  input  logic [4:0]       disp_rs2,
  output logic [XLEN-1:0]  rs1_val,
  output logic [TAG_W-1:0] rs1_rely,
  output logic [XLEN-1:0]  rs2_val,
  output logic [TAG_W-1:0] rs2_rely,
  input  logic             write_rdy,
  input  logic [4:0]       to_rd,
  input  logic [XLEN-1:0]  write_val,
  input  logic [TAG_W-1:0] head_tag,
  output logic [5:0]       pending_cnt
);

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [TAG_W-1:0] tags [NUM_REGS];

  logic commit_en;
  logic dispatch_en;

  assign commit_en   = rdy_in & write_rdy & (to_rd != 5'd0);
  assign dispatch_en = rdy_in & dispatch_rdy & ~clear & (disp_rd != 5'd0);

  // Register values and rename tags. Entry 0 is only ever reset, so x0 stays zero and untagged.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        // The commit value is written even during a flush (jal/jalr link register).
        if (commit_en && (to_rd == 5'(i))) begin
          regs[i] <= write_val;
        end
        // Priority order: flush, then a newer rename, then release by a matching commit.
        // An older commit never releases a newer rename.
        if (clear) begin
          tags[i] <= '0;
        end else if (dispatch_en && (disp_rd == 5'(i))) begin
          tags[i] <= disp_tag;
        end else if (commit_en && (to_rd == 5'(i)) && (tags[i] == head_tag)) begin
          tags[i] <= '0;
        end
      end
    end
  end

  // Source 1 read. A commit that is retiring the pending producer is forwarded in the same cycle.
  always_comb begin
    rs1_val  = regs[disp_rs1];
    rs1_rely = tags[disp_rs1];
    if (disp_rs1 == 5'd0) begin
      rs1_val  = '0;
      rs1_rely = '0;
    end else if (commit_en && (to_rd == disp_rs1) && (tags[disp_rs1] == head_tag)) begin
      rs1_val  = write_val;
      rs1_rely = '0;
    end else begin
      rs1_val  = regs[disp_rs1];
      rs1_rely = tags[disp_rs1];
    end
  end

  // Source 2 read, with the same commit forwarding as source 1.
  always_comb begin
    rs2_val  = regs[disp_rs2];
    rs2_rely = tags[disp_rs2];
    if (disp_rs2 == 5'd0) begin
      rs2_val  = '0;
      rs2_rely = '0;
    end else if (commit_en && (to_rd == disp_rs2) && (tags[disp_rs2] == head_tag)) begin
      rs2_val  = write_val;
      rs2_rely = '0;
    end else begin
      rs2_val  = regs[disp_rs2];
      rs2_rely = tags[disp_rs2];
    end
  end

  // Population count of the registers that have a nonzero tag.
  always_comb begin
    pending_cnt = 6'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (tags[i] != '0) begin
        pending_cnt = pending_cnt + 6'd1;
      end else begin
        pending_cnt = pending_cnt;
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file
//   Directed vector table for reg_rename_file. Each record drives one cycle of
//   inputs. Before the clock edge that commits those inputs, the record gives
//   the expected combinational outputs. A hand-written sequence then covers a
//   mid-cycle asynchronous reset.
module tb_reg_rename_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        dispatch_rdy;
  logic [4:0]  disp_rd;
  logic [4:0]  disp_tag;
  logic [4:0]  disp_rs1;
  logic [4:0]  disp_rs2;
  logic [31:0] rs1_val;
  logic [4:0]  rs1_rely;
  logic [31:0] rs2_val;
  logic [4:0]  rs2_rely;
  logic        write_rdy;
  logic [4:0]  to_rd;
  logic [31:0] write_val;
  logic [4:0]  head_tag;
  logic [5:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  reg_rename_file #(.NUM_REGS(32), .TAG_W(5), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dispatch_rdy(dispatch_rdy), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .rs1_val(rs1_val), .rs1_rely(rs1_rely), .rs2_val(rs2_val), .rs2_rely(rs2_rely),
    .write_rdy(write_rdy), .to_rd(to_rd), .write_val(write_val), .head_tag(head_tag),
    .pending_cnt(pending_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        clr;
    logic        disp;
    logic [4:0]  rd;
    logic [4:0]  dtag;
    logic        wr;
    logic [4:0]  wrd;
    logic [31:0] wval;
    logic [4:0]  head;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1v;
    logic [4:0]  e1r;
    logic [31:0] e2v;
    logic [4:0]  e2r;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic clr, input logic disp, input logic [4:0] rd,
                     input logic [4:0] dtag, input logic wr, input logic [4:0] wrd,
                     input logic [31:0] wval, input logic [4:0] head,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] e1v, input logic [4:0] e1r,
                     input logic [31:0] e2v, input logic [4:0] e2r, input logic [5:0] ecnt);
    vec_t v;
    v.rdy = rdy; v.clr = clr; v.disp = disp; v.rd = rd; v.dtag = dtag;
    v.wr = wr; v.wrd = wrd; v.wval = wval; v.head = head; v.rs1 = rs1; v.rs2 = rs2;
    v.e1v = e1v; v.e1r = e1r; v.e2v = e2v; v.e2r = e2r; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy_in = v.rdy; clear = v.clr; dispatch_rdy = v.disp; disp_rd = v.rd; disp_tag = v.dtag;
    write_rdy = v.wr; to_rd = v.wrd; write_val = v.wval; head_tag = v.head;
    disp_rs1 = v.rs1; disp_rs2 = v.rs2;
  endtask

  initial begin
    vec_t idle;
    // Columns: rdy clr disp rd dtag | wr to_rd wval head | rs1 rs2 | exp rs1 val/rely, rs2 val/rely, cnt
    add(1,0,0, 0,0, 0, 0,32'h0,0,  5, 6, 32'h0,0, 32'h0,0, 6'd0);        // 0 reset state
    add(1,0,1, 5,3, 0, 0,32'h0,0,  5, 0, 32'h0,0, 32'h0,0, 6'd0);        // 1 dispatch x5 tag 3
    add(1,0,0, 0,0, 0, 0,32'h0,0,  5, 0, 32'h0,3, 32'h0,0, 6'd1);        // 2 x5 pending on 3
    add(1,0,0, 0,0, 1, 5,32'hDEADBEEF,3, 5, 0, 32'hDEADBEEF,0, 32'h0,0, 6'd1); // 3 commit bypass
    add(1,0,0, 0,0, 0, 0,32'h0,0,  5, 0, 32'hDEADBEEF,0, 32'h0,0, 6'd0); // 4 tag released
    add(1,0,1, 7,2, 0, 0,32'h0,0,  7, 0, 32'h0,0, 32'h0,0, 6'd0);        // 5 x7 tag 2
    add(1,0,1, 7,4, 0, 0,32'h0,0,  7, 0, 32'h0,2, 32'h0,0, 6'd1);        // 6 x7 renamed to 4
    add(1,0,0, 0,0, 1, 7,32'h11,2, 7, 5, 32'h0,4, 32'hDEADBEEF,0, 6'd1); // 7 stale commit: no bypass
    add(1,0,0, 0,0, 0, 0,32'h0,0,  7, 0, 32'h11,4, 32'h0,0, 6'd1);       // 8 value written, tag kept
    add(1,0,1, 9,6, 1, 9,32'h99,1, 9, 0, 32'h0,0, 32'h0,0, 6'd1);        // 9 same-cycle commit+dispatch
    add(1,0,0, 0,0, 0, 0,32'h0,0,  9, 7, 32'h99,6, 32'h11,4, 6'd2);      // 10 dispatch tag wins
    add(0,0,1,10,5, 1, 5,32'h1234,0, 10, 5, 32'h0,0, 32'hDEADBEEF,0, 6'd2); // 11 rdy_in=0: no bypass
    add(1,0,0, 0,0, 0, 0,32'h0,0, 10, 5, 32'h0,0, 32'hDEADBEEF,0, 6'd2); // 12 nothing written
    add(1,0,0, 0,0, 1, 5,32'h5555,0, 5, 0, 32'h5555,0, 32'h0,0, 6'd2);   // 13 commit of untagged reg
    add(1,0,0, 0,0, 0, 0,32'h0,0,  5, 0, 32'h5555,0, 32'h0,0, 6'd2);     // 14
    add(1,0,1, 1,1, 0, 0,32'h0,0,  1, 0, 32'h0,0, 32'h0,0, 6'd2);        // 15 tag x1..x4
    add(1,0,1, 2,2, 0, 0,32'h0,0,  1, 0, 32'h0,1, 32'h0,0, 6'd3);        // 16
    add(1,0,1, 3,3, 0, 0,32'h0,0,  2, 0, 32'h0,2, 32'h0,0, 6'd4);        // 17
    add(1,0,1, 4,4, 0, 0,32'h0,0,  3, 0, 32'h0,3, 32'h0,0, 6'd5);        // 18
    add(1,1,1,11,8, 1, 1,32'h80,7, 4, 1, 32'h0,4, 32'h0,1, 6'd6);        // 19 clear + commit + dispatch
    add(1,0,0, 0,0, 0, 0,32'h0,0,  1, 9, 32'h80,0, 32'h99,0, 6'd0);      // 20 tags flushed, link written
    add(1,0,0, 0,0, 0, 0,32'h0,0, 11, 4, 32'h0,0, 32'h0,0, 6'd0);        // 21 dispatch was dropped
    add(1,0,1, 0,5, 1, 0,32'h55,0, 0, 0, 32'h0,0, 32'h0,0, 6'd0);        // 22 x0 write/dispatch
    add(1,0,0, 0,0, 0, 0,32'h0,0,  0, 0, 32'h0,0, 32'h0,0, 6'd0);        // 23 x0 still zero/untagged

    idle = '{rdy:1'b1, clr:1'b0, disp:1'b0, rd:5'd0, dtag:5'd0, wr:1'b0, wrd:5'd0,
             wval:32'h0, head:5'd0, rs1:5'd0, rs2:5'd0, e1v:32'h0, e1r:5'd0,
             e2v:32'h0, e2r:5'd0, ecnt:6'd0};
    drive(idle);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk_in);
      #1;
      drive(vecs[i]);
      @(negedge clk_in);
      check($sformatf("v%0d_rs1_val", i),  rs1_val,  vecs[i].e1v);
      check($sformatf("v%0d_rs1_rely", i), {27'd0, rs1_rely}, {27'd0, vecs[i].e1r});
      check($sformatf("v%0d_rs2_val", i),  rs2_val,  vecs[i].e2v);
      check($sformatf("v%0d_rs2_rely", i), {27'd0, rs2_rely}, {27'd0, vecs[i].e2r});
      check($sformatf("v%0d_pending", i),  {26'd0, pending_cnt}, {26'd0, vecs[i].ecnt});
    end

    // Mid-cycle asynchronous reset: tag x12, then assert rst_in between edges.
    @(posedge clk_in);
    #1;
    drive(idle);
    dispatch_rdy = 1'b1; disp_rd = 5'd12; disp_tag = 5'd9;
    @(posedge clk_in);
    #1;
    drive(idle);
    disp_rs1 = 5'd12; disp_rs2 = 5'd1;
    @(negedge clk_in);
    check("pre_rst_rs1_rely", {27'd0, rs1_rely}, 32'd9);
    check("pre_rst_rs2_val",  rs2_val, 32'h80);
    check("pre_rst_pending",  {26'd0, pending_cnt}, 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_rs1_rely", {27'd0, rs1_rely}, 32'd0);
    check("async_rst_rs2_val",  rs2_val, 32'h0);
    check("async_rst_pending",  {26'd0, pending_cnt}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    disp_rs1 = 5'd5; disp_rs2 = 5'd9;
    #1;
    check("post_rst_x5_val", rs1_val, 32'h0);
    check("post_rst_x9_val", rs2_val, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
